// File: rtl/riscv_register_file_sb_if.sv
// riscv_register_file_sb_if: read, write-back, scoreboard and status signals of the scoreboarded register file
interface riscv_register_file_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ = 3
);
  logic [NUM_READ*ADDR_WIDTH-1:0] raddr_i;
  logic [NUM_READ*DATA_WIDTH-1:0] rdata_o;
  logic [NUM_READ-1:0] rbusy_o;
  logic [ADDR_WIDTH-1:0] waddr_a_i;
  logic [DATA_WIDTH-1:0] wdata_a_i;
  logic we_a_i;
  logic [ADDR_WIDTH-1:0] waddr_b_i;
  logic [DATA_WIDTH-1:0] wdata_b_i;
  logic we_b_i;
  logic resv_i;
  logic [ADDR_WIDTH-1:0] resv_addr_i;
  logic flush_i;
  logic [ADDR_WIDTH:0] busy_cnt_o;
  logic wr_conflict_o;
  modport master (
    output raddr_i, waddr_a_i, wdata_a_i, we_a_i, waddr_b_i, wdata_b_i, we_b_i, resv_i, resv_addr_i, flush_i,
    input rdata_o, rbusy_o, busy_cnt_o, wr_conflict_o
  );
  modport slave (
    input raddr_i, waddr_a_i, wdata_a_i, we_a_i, waddr_b_i, wdata_b_i, we_b_i, resv_i, resv_addr_i, flush_i,
    output rdata_o, rbusy_o, busy_cnt_o, wr_conflict_o
  );
endinterface

// File: rtl/riscv_register_file_sb.sv
// riscv_register_file_sb: register file with two prioritised write ports, read forwarding and a busy scoreboard
module riscv_register_file_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  riscv_register_file_sb_if.slave rf
);
  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  // a hardwired register 0 is removed from every write, reservation and release decode
  localparam logic [NUM_WORDS-1:0] MASK = ~NUM_WORDS'(ZERO_REG != 0);
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [NUM_WORDS-1:0] wa_hit, wb_hit, rs_hit, busy, busy_nxt;
  logic [CW-1:0] busy_cnt, cnt_nxt;
  logic wr_conflict, conflict_nxt;
  always_comb begin
    wa_hit = rf.we_a_i ? (NUM_WORDS'(1) << rf.waddr_a_i) & MASK : '0;
    wb_hit = rf.we_b_i ? (NUM_WORDS'(1) << rf.waddr_b_i) & MASK : '0;
    rs_hit = rf.resv_i ? (NUM_WORDS'(1) << rf.resv_addr_i) & MASK : '0;
    busy_nxt = rf.flush_i ? '0 : (busy & ~wb_hit) | rs_hit;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_WORDS; i++) cnt_nxt += CW'(busy_nxt[i]);
    conflict_nxt = rf.we_b_i && rf.waddr_a_i == rf.waddr_b_i && wa_hit != '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    else for (int i = 0; i < NUM_WORDS; i++)
      if (wb_hit[i]) mem[i] <= rf.wdata_b_i;
      else if (wa_hit[i]) mem[i] <= rf.wdata_a_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= '0;
      busy_cnt <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
      wr_conflict <= conflict_nxt;
    end
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic zero, fwd_a, fwd_b;
    assign ra = rf.raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero = ZERO_REG != 0 && ra == '0;
    assign fwd_b = BYPASS != 0 && rf.we_b_i && rf.waddr_b_i == ra;
    assign fwd_a = BYPASS != 0 && rf.we_a_i && rf.waddr_a_i == ra;
    assign rf.rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = zero ? '0 : fwd_b ? rf.wdata_b_i : fwd_a ? rf.wdata_a_i : mem[ra];
    // a register being released this cycle is already forwarded, so it no longer stalls
    assign rf.rbusy_o[k] = !zero && !fwd_b && busy[ra];
  end
  assign rf.busy_cnt_o = busy_cnt;
  assign rf.wr_conflict_o = wr_conflict;
endmodule

// File: tb/tb_riscv_register_file_sb.sv
// tb_riscv_register_file_sb: two configurations driven with shared directed and random stimulus, checked against a behavioural model
module tb_riscv_register_file_sb;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] waddr_a, waddr_b, resv_addr;
  logic [31:0] wdata_a, wdata_b;
  logic we_a, we_b, resv, flush;
  logic [14:0] raddr0;
  logic [19:0] raddr1;
  int total = 0;
  int bad = 0;
  logic [31:0] m_mem [2][32];
  bit m_busy [2][32];
  int m_cnt [2];
  bit m_conf [2];
  always #5 clk = ~clk;
  riscv_register_file_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(3)) bus0 ();
  riscv_register_file_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(4)) bus1 ();
  assign bus0.raddr_i = raddr0;
  assign bus1.raddr_i = raddr1;
  assign {bus0.waddr_a_i, bus0.wdata_a_i, bus0.we_a_i, bus0.waddr_b_i, bus0.wdata_b_i, bus0.we_b_i} = {waddr_a, wdata_a, we_a, waddr_b, wdata_b, we_b};
  assign {bus1.waddr_a_i, bus1.wdata_a_i, bus1.we_a_i, bus1.waddr_b_i, bus1.wdata_b_i, bus1.we_b_i} = {waddr_a, wdata_a, we_a, waddr_b, wdata_b, we_b};
  assign {bus0.resv_i, bus0.resv_addr_i, bus0.flush_i} = {resv, resv_addr, flush};
  assign {bus1.resv_i, bus1.resv_addr_i, bus1.flush_i} = {resv, resv_addr, flush};
  riscv_register_file_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(3), .ZERO_REG(1), .BYPASS(1)) u0 (.clk(clk), .rst(rst), .rf(bus0));
  riscv_register_file_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(4), .ZERO_REG(0), .BYPASS(0)) u1 (.clk(clk), .rst(rst), .rf(bus1));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] exp_rd(input int j, input logic [4:0] a);
    if (j == 0 && a == 0) return 32'h0;
    if (j == 0 && we_b && waddr_b == a) return wdata_b;
    if (j == 0 && we_a && waddr_a == a) return wdata_a;
    return m_mem[j][a];
  endfunction
  function automatic logic exp_busy(input int j, input logic [4:0] a);
    if (j == 0 && a == 0) return 1'b0;
    if (j == 0 && we_b && waddr_b == a) return 1'b0;
    return m_busy[j][a];
  endfunction
  task automatic model_clear();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[j][i] = 32'h0;
        m_busy[j][i] = 1'b0;
      end
      m_cnt[j] = 0;
      m_conf[j] = 1'b0;
    end
  endtask
  task automatic settle();
    #1;
    if (rst) model_clear();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u0 rdata%0d", k), bus0.rdata_o[k*32 +: 32], exp_rd(0, raddr0[k*5 +: 5]));
      chk($sformatf("u0 rbusy%0d", k), 32'(bus0.rbusy_o[k]), 32'(exp_busy(0, raddr0[k*5 +: 5])));
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u1 rdata%0d", k), bus1.rdata_o[k*32 +: 32], exp_rd(1, raddr1[k*5 +: 5]));
      chk($sformatf("u1 rbusy%0d", k), 32'(bus1.rbusy_o[k]), 32'(exp_busy(1, raddr1[k*5 +: 5])));
    end
    chk("u0 busy_cnt", 32'(bus0.busy_cnt_o), 32'(m_cnt[0]));
    chk("u1 busy_cnt", 32'(bus1.busy_cnt_o), 32'(m_cnt[1]));
    chk("u0 wr_conflict", 32'(bus0.wr_conflict_o), 32'(m_conf[0]));
    chk("u1 wr_conflict", 32'(bus1.wr_conflict_o), 32'(m_conf[1]));
  endtask
  task automatic advance();
    @(posedge clk);
    if (rst) model_clear();
    else for (int j = 0; j < 2; j++) begin
      bit zr;
      zr = (j == 0);
      if (we_b && !(zr && waddr_b == 0)) m_mem[j][waddr_b] = wdata_b;
      if (we_a && !(zr && waddr_a == 0) && !(we_b && waddr_b == waddr_a)) m_mem[j][waddr_a] = wdata_a;
      if (flush) for (int i = 0; i < 32; i++) m_busy[j][i] = 1'b0;
      else begin
        if (we_b) m_busy[j][waddr_b] = 1'b0;
        if (resv && !(zr && resv_addr == 0)) m_busy[j][resv_addr] = 1'b1;
      end
      m_conf[j] = we_a && we_b && waddr_a == waddr_b && !(zr && waddr_a == 0);
      m_cnt[j] = 0;
      for (int i = 0; i < 32; i++) m_cnt[j] += int'(m_busy[j][i]);
    end
    @(negedge clk);
  endtask
  task automatic idle();
    {we_a, we_b, resv, flush, rst} = '0;
  endtask
  task automatic rd_all(input logic [4:0] a);
    raddr0 = {3{a}};
    raddr1 = {4{a}};
  endtask
  initial begin
    model_clear();
    idle();
    {waddr_a, waddr_b, resv_addr, wdata_a, wdata_b} = '0;
    rd_all(5'd5);
    rst = 1'b1;
    @(negedge clk);
    settle();
    chk("reset busy_cnt", 32'(bus0.busy_cnt_o), 32'h0);
    advance();
    // reset held while a write is presented: forwarded but never stored
    rst = 1'b1;
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF;
    settle();
    chk("reset fwd r5", bus0.rdata_o[31:0], 32'hDEADBEEF);
    advance();
    idle();
    settle();
    chk("reset r5 u0", bus0.rdata_o[31:0], 32'h0);
    chk("reset r5 u1", bus1.rdata_o[31:0], 32'h0);
    chk("reset cnt u1", 32'(bus1.busy_cnt_o), 32'h0);
    advance();
    rd_all(5'd7);
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11;
    we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22;
    settle();
    chk("collide fwd u0", bus0.rdata_o[31:0], 32'h22);
    chk("collide old u1", bus1.rdata_o[95:64], 32'h0);
    advance();
    idle();
    settle();
    chk("collide r7 u0", bus0.rdata_o[63:32], 32'h22);
    chk("collide r7 u1", bus1.rdata_o[127:96], 32'h22);
    chk("conflict set", 32'(bus0.wr_conflict_o), 32'h1);
    advance();
    settle();
    chk("conflict clear", 32'(bus0.wr_conflict_o), 32'h0);
    advance();
    rd_all(5'd0);
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF;
    resv = 1'b1; resv_addr = 5'd0;
    settle();
    chk("r0 fwd zero", bus0.rdata_o[31:0], 32'h0);
    advance();
    idle();
    settle();
    chk("r0 zero u0", bus0.rdata_o[31:0], 32'h0);
    chk("r0 busy u0", 32'(bus0.rbusy_o), 32'h0);
    chk("r0 cnt u0", 32'(bus0.busy_cnt_o), 32'h0);
    chk("r0 plain u1", bus1.rdata_o[31:0], 32'hFFFFFFFF);
    chk("r0 cnt u1", 32'(bus1.busy_cnt_o), 32'h1);
    advance();
    flush = 1'b1;
    settle();
    advance();
    idle();
    rd_all(5'd3);
    for (int i = 0; i < 3; i++) begin
      resv = 1'b1;
      resv_addr = (i == 1) ? 5'd4 : 5'd3;
      settle();
      advance();
    end
    idle();
    we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'h55;
    settle();
    chk("sb cnt 2", 32'(bus0.busy_cnt_o), 32'h2);
    chk("release busy u0", 32'(bus0.rbusy_o[0]), 32'h0);
    chk("release data u0", bus0.rdata_o[31:0], 32'h55);
    chk("release busy u1", 32'(bus1.rbusy_o[0]), 32'h1);
    advance();
    idle();
    settle();
    chk("sb cnt 1", 32'(bus0.busy_cnt_o), 32'h1);
    advance();
    rd_all(5'd9);
    resv = 1'b1; resv_addr = 5'd9;
    we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h99;
    settle();
    advance();
    idle();
    settle();
    chk("race data", bus0.rdata_o[31:0], 32'h99);
    chk("race busy", 32'(bus0.rbusy_o[0]), 32'h1);
    advance();
    rd_all(5'd10);
    flush = 1'b1; resv = 1'b1; resv_addr = 5'd10;
    settle();
    advance();
    idle();
    settle();
    chk("flush cnt", 32'(bus0.busy_cnt_o), 32'h0);
    chk("flush r10", 32'(bus1.rbusy_o), 32'h0);
    advance();
    rd_all(5'd12);
    we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'hA5A5A5A5;
    settle();
    chk("nobypass old", bus1.rdata_o, 128'h0);
    advance();
    idle();
    settle();
    chk("nobypass new 3", bus1.rdata_o[127:96], 32'hA5A5A5A5);
    chk("nobypass new 0", bus1.rdata_o[31:0], 32'hA5A5A5A5);
    advance();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] lim;
      lim = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      we_a = $urandom_range(0, 1);
      we_b = ($urandom_range(0, 2) == 0);
      resv = ($urandom_range(0, 2) == 0);
      waddr_a = 5'($urandom_range(0, 32'(lim)));
      waddr_b = 5'($urandom_range(0, 32'(lim)));
      resv_addr = 5'($urandom_range(0, 32'(lim)));
      wdata_a = $urandom;
      wdata_b = $urandom;
      for (int k = 0; k < 3; k++) raddr0[k*5 +: 5] = 5'($urandom_range(0, 32'(lim)));
      for (int k = 0; k < 4; k++) raddr1[k*5 +: 5] = 5'($urandom_range(0, 32'(lim)));
      settle();
      advance();
    end
    idle();
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_register_file_sb.md
# riscv_register_file_sb

Parametrised, scoreboarded integer register file for the RI5CY pipeline: 2^ADDR_WIDTH words, NUM_READ combinational read ports and two prioritised write ports. It adds optional same-cycle write-to-read forwarding and a per-register busy scoreboard. Long-latency producers (loads, multi-cycle ops) reserve their destination at issue and release it on write-back. It sits between the ID stage, which reads operands and checks hazards, and the EX/WB stages, which perform write-back.

## Interface
- ADDR_WIDTH, 5: address width; the file has NUM_WORDS = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width.
- NUM_READ, 3: number of read ports, 1..4.
- ZERO_REG, 1: 1 = register 0 always reads zero and ignores writes and reservations; 0 = register 0 is an ordinary register.
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports; 0 = reads return stored contents only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr_i  in  NUM_READ*ADDR_WIDTH  read addresses; port k uses slice k.
- rdata_o  out  NUM_READ*DATA_WIDTH  read data; port k uses slice k.
- rbusy_o  out  NUM_READ  scoreboard busy flag of each addressed register.
- waddr_a_i, wdata_a_i, we_a_i  in  ADDR_WIDTH/DATA_WIDTH/1  write port A (ALU write-back).
- waddr_b_i, wdata_b_i, we_b_i  in  ADDR_WIDTH/DATA_WIDTH/1  write port B (long-latency write-back). Port B has priority over port A.
- resv_i, resv_addr_i  in  1/ADDR_WIDTH  reserve (mark busy) one register.
- flush_i  in  1  clear every busy bit.
- busy_cnt_o  out  ADDR_WIDTH+1  number of registers currently busy.
- wr_conflict_o  out  1  one-cycle flag: both write ports targeted the same address in the previous cycle.

## Operation
- Storage and writes:
  - On each edge, a word is written from port B if we_b_i addresses it, else from port A if we_a_i addresses it, else it holds.
  - When both ports target the same address, port B data is kept and port A data is discarded.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads are combinational. For each port k:
  - If ZERO_REG=1 and the address is 0, return 0.
  - Else, if BYPASS=1 and we_b_i targets the address, return wdata_b_i.
  - Else, if BYPASS=1 and we_a_i targets the address, return wdata_a_i.
  - Else return the stored word.
- Scoreboard: one busy bit per word, updated on the edge. Per-bit priority, highest first:
  - flush_i clears the bit; a resv_i in the same cycle is dropped.
  - resv_i at that address sets the bit. If we_b_i hits the same address in the same cycle, set still wins; the reservation is new.
  - we_b_i at that address clears the bit.
  - Otherwise the bit holds.
- Port A writes never change busy bits.
- With ZERO_REG=1, reservations of register 0 are ignored and its busy bit is constant 0.
- rbusy_o[k] is the busy bit of raddr_i slice k. With BYPASS=1 it reads 0 while we_b_i targets that address in the current cycle, since the value is being forwarded. With BYPASS=0 it reports the stored bit.
- busy_cnt_o is a registered counter. After every edge it equals the population count of the busy vector, ranging 0..NUM_WORDS (or NUM_WORDS-1 when ZERO_REG=1). Flush loads 0.
  - Reserving an already-busy register: no change.
  - Clearing a non-busy register: no change.
- wr_conflict_o is registered. It is 1 in the cycle after we_a_i && we_b_i && waddr_a_i == waddr_b_i, excluding address 0 when ZERO_REG=1.

## Timing
- Reset (asynchronous, any cycle, including mid-write): all words 0, all busy bits 0, busy_cnt_o = 0, wr_conflict_o = 0.
  - With reset asserted, rdata_o = 0 unless forwarding is active. The writes themselves are inhibited.
- Write latency:
  - BYPASS=1: write data is visible on rdata_o in the same cycle, and stored from the next cycle.
  - BYPASS=0: write data is visible from the next cycle.
- Scoreboard latency:
  - A reserve issued in cycle N shows rbusy_o = 1 from cycle N+1.
  - A release by we_b_i in cycle N shows rbusy_o = 0 in cycle N (BYPASS=1) or N+1 (BYPASS=0).
- busy_cnt_o and wr_conflict_o reflect cycle N events in cycle N+1.
- All read ports are independent; identical addresses on several ports are legal.

## Test plan
- Reset mid-write: write 0xDEADBEEF to r5 and assert rst in the same cycle -> r5 reads 0 after reset; busy_cnt_o = 0.
- Collision: port A writes 0x11 and port B writes 0x22 to r7 in the same cycle -> rdata = 0x22 in that cycle (BYPASS=1), r7 holds 0x22, wr_conflict_o = 1 in the next cycle only.
- Zero register, ZERO_REG=1: write 0xFFFFFFFF to r0 and reserve r0 -> r0 reads 0, rbusy_o = 0, busy_cnt_o unchanged. With ZERO_REG=0: r0 reads 0xFFFFFFFF.
- Scoreboard: reserve r3, r4, r3 on consecutive cycles -> busy_cnt_o = 1, 2, 2. Port B writes r3 = 0x55 -> rbusy_o = 0 and rdata = 0x55 in the same cycle; busy_cnt_o = 1 in the next cycle.
- Set/clear race: reserve r9 while port B writes r9 -> r9 holds the new data and stays busy. Flush with a simultaneous reserve of r10 -> all busy bits 0, busy_cnt_o = 0.
- BYPASS=0, NUM_READ=4: write r12 = 0xA5A5A5A5 -> all four ports read the old value in the write cycle and 0xA5A5A5A5 in the next cycle.
